// File: rtl/pueo_turf_trig_arbiter.sv
// Round-robin arbiter for the TURF trigger issue slot, 4 requesters.
// Optional PUEO_TRIG_ARB_PPS_PRIO_EN: pps (src 1) wins every eligible slot.
module pueo_turf_trig_arbiter #(
  parameter int NSRC  = 4,
  parameter int HOLDW = 8,
  parameter int DROPW = 16
) (
  input  logic                  sysclk_i,
  input  logic                  sysclk_rstn_i,
  input  logic                  slot_ce_i,
  input  logic                  runrst_i,
  input  logic [NSRC-1:0]       src_en_i,
  input  logic [HOLDW-1:0]      holdoff_i,
  input  logic [NSRC*12-1:0]    req_trig_i,
  input  logic [NSRC*8-1:0]     req_meta_i,
  input  logic [NSRC-1:0]       req_valid_i,
  output logic [11:0]           trig_o,
  output logic [7:0]            meta_o,
  output logic [1:0]            src_o,
  output logic                  valid_o,
  output logic [NSRC-1:0]       pending_o,
  output logic [NSRC*DROPW-1:0] drop_cnt_o
);

  logic [NSRC-1:0]  pend_q, pend_d;
  logic [11:0]      tbuf_q [NSRC];
  logic [7:0]       mbuf_q [NSRC];
  logic [DROPW-1:0] drop_q [NSRC];
  logic [HOLDW-1:0] hold_q, hold_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [11:0]      trig_q;
  logic [7:0]       meta_q;
  logic [1:0]       src_q;
  logic             valid_q;

  logic [NSRC-1:0]  elig, gnt_vec, cap, drop;
  logic [1:0]       win, idx;
  logic             found, gnt, ptr_upd;

  always_comb begin
    elig    = pend_q & src_en_i;
    win     = ptr_q;
    idx     = ptr_q;
    found   = 1'b0;
    ptr_upd = 1'b1;
    for (int i = 1; i <= NSRC; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && elig[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
`ifdef PUEO_TRIG_ARB_PPS_PRIO_EN
    // pps jumps the queue without disturbing the rr pointer
    if (elig[1]) begin
      win     = 2'd1;
      ptr_upd = 1'b0;
    end
`endif
    gnt     = slot_ce_i && (hold_q == '0) && (|elig);
    gnt_vec = '0;
    if (gnt) gnt_vec[win] = 1'b1;
  end

  always_comb begin
    cap    = '0;
    drop   = '0;
    pend_d = '0;
    for (int k = 0; k < NSRC; k++) begin
      cap[k]  = req_valid_i[k] && src_en_i[k] &&
                (!pend_q[k] || gnt_vec[k]);
      drop[k] = req_valid_i[k] && src_en_i[k] &&
                pend_q[k] && !gnt_vec[k];
      pend_d[k] = src_en_i[k] &&
                  (cap[k] || (pend_q[k] && !gnt_vec[k]));
    end
    if (runrst_i) pend_d = '0;
  end

  always_comb begin
    hold_d = hold_q;
    ptr_d  = ptr_q;
    if (slot_ce_i && (hold_q != '0)) begin
      hold_d = hold_q - 1'b1;
    end else if (gnt) begin
      hold_d = holdoff_i;
      if (ptr_upd) ptr_d = win;
    end
    if (runrst_i) begin
      hold_d = '0;
      ptr_d  = 2'd3;
    end
  end

  always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
    if (!sysclk_rstn_i) begin
      pend_q  <= '0;
      hold_q  <= '0;
      ptr_q   <= 2'd3;
      trig_q  <= '0;
      meta_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      for (int k = 0; k < NSRC; k++) begin
        tbuf_q[k] <= '0;
        mbuf_q[k] <= '0;
        drop_q[k] <= '0;
      end
    end else begin
      pend_q  <= pend_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
      valid_q <= gnt && !runrst_i;
      if (gnt && !runrst_i) begin
        trig_q <= tbuf_q[win];
        meta_q <= mbuf_q[win];
        src_q  <= win;
      end
      for (int k = 0; k < NSRC; k++) begin
        if (cap[k]) begin
          tbuf_q[k] <= req_trig_i[k*12 +: 12];
          mbuf_q[k] <= req_meta_i[k*8 +: 8];
        end
        if (runrst_i) begin
          drop_q[k] <= '0;
        end else if (drop[k] && (drop_q[k] != '1)) begin
          drop_q[k] <= drop_q[k] + 1'b1;
        end
      end
    end
  end

  assign trig_o    = trig_q;
  assign meta_o    = meta_q;
  assign src_o     = src_q;
  assign valid_o   = valid_q;
  assign pending_o = pend_q;

  for (genvar g = 0; g < NSRC; g++) begin : g_drop
    assign drop_cnt_o[g*DROPW +: DROPW] = drop_q[g];
  end

endmodule

// File: tb/tb_pueo_turf_trig_arbiter.sv
// Directed bench for pueo_turf_trig_arbiter.
// Expected grant order follows PUEO_TRIG_ARB_PPS_PRIO_EN when defined.
module tb_pueo_turf_trig_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slot_ce = 1'b0;
  logic        runrst = 1'b0;
  logic [3:0]  src_en = 4'hF;
  logic [7:0]  holdoff = 8'd0;
  logic [47:0] req_trig = '0;
  logic [31:0] req_meta = '0;
  logic [3:0]  req_valid = '0;
  logic [11:0] trig;
  logic [7:0]  meta;
  logic [1:0]  src;
  logic        valid;
  logic [3:0]  pending;
  logic [63:0] drops;

  int checks = 0;
  int failures = 0;

  pueo_turf_trig_arbiter dut (
    .sysclk_i      (clk),
    .sysclk_rstn_i (rst_n),
    .slot_ce_i     (slot_ce),
    .runrst_i      (runrst),
    .src_en_i      (src_en),
    .holdoff_i     (holdoff),
    .req_trig_i    (req_trig),
    .req_meta_i    (req_meta),
    .req_valid_i   (req_valid),
    .trig_o        (trig),
    .meta_o        (meta),
    .src_o         (src),
    .valid_o       (valid),
    .pending_o     (pending),
    .drop_cnt_o    (drops)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int k,
                       input logic [11:0] t,
                       input logic [7:0] m);
    req_trig[k*12 +: 12] = t;
    req_meta[k*8 +: 8]   = m;
    req_valid[k] = 1'b1;
    tick();
    req_valid = '0;
  endtask

  task automatic slot();
    slot_ce = 1'b1;
    tick();
    slot_ce = 1'b0;
  endtask

  int          ord2 [4] = '{1, 2, 3, 0};
  logic [11:0] trg2 [4] = '{12'h102, 12'h203, 12'h304, 12'h001};
`ifdef PUEO_TRIG_ARB_PPS_PRIO_EN
  int          ord6 [3] = '{1, 0, 2};
`else
  int          ord6 [3] = '{0, 1, 2};
`endif

  initial begin
    #23 rst_n = 1'b1;
    tick();
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_trig", 64'(trig), 64'd0);
    check("rst_pend", 64'(pending), 64'd0);
    check("rst_drop", drops, 64'd0);

    // single request, slot 3 clks later
    pulse(0, 12'h123, 8'hA5);
    check("t1_pend", 64'(pending), 64'h1);
    tick();
    tick();
    slot();
    check("t1_valid", 64'(valid), 64'd1);
    check("t1_trig", 64'(trig), 64'h123);
    check("t1_meta", 64'(meta), 64'hA5);
    check("t1_src", 64'(src), 64'd0);
    check("t1_pend0", 64'(pending), 64'd0);
    tick();
    check("t1_vlow", 64'(valid), 64'd0);
    check("t1_hold", 64'(trig), 64'h123);

    // all four pending, round robin from ptr=0
    req_trig  = {12'h304, 12'h203, 12'h102, 12'h001};
    req_meta  = {8'h33, 8'h22, 8'h11, 8'h00};
    req_valid = 4'hF;
    tick();
    req_valid = '0;
    check("t2_pend", 64'(pending), 64'hF);
    for (int i = 0; i < 4; i++) begin
      slot();
      check("t2_valid", 64'(valid), 64'd1);
      check("t2_src", 64'(src), 64'(ord2[i]));
      check("t2_trig", 64'(trig), 64'(trg2[i]));
      tick();
      check("t2_gap", 64'(valid), 64'd0);
    end

    // holdoff of 2, change mid-holdoff has no effect
    holdoff = 8'd2;
    req_trig[12 +: 12] = 12'h111;
    req_trig[24 +: 12] = 12'h222;
    req_valid = 4'b0110;
    tick();
    req_valid = '0;
    slot();
    check("t3_g1", 64'(valid), 64'd1);
    check("t3_s1", 64'(src), 64'd1);
    holdoff = 8'd5;
    slot();
    check("t3_idle1", 64'(valid), 64'd0);
    slot();
    check("t3_idle2", 64'(valid), 64'd0);
    slot();
    check("t3_g2", 64'(valid), 64'd1);
    check("t3_s2", 64'(src), 64'd2);
    check("t3_t2", 64'(trig), 64'h222);
    holdoff = 8'd0;
    repeat (5) slot();

    // overflow drops, first payload kept
    pulse(2, 12'hA01, 8'h01);
    pulse(2, 12'hA02, 8'h02);
    pulse(2, 12'hA03, 8'h03);
    check("t4_pend", 64'(pending), 64'h4);
    check("t4_drop", drops, 64'h2_0000_0000);
    slot();
    check("t4_valid", 64'(valid), 64'd1);
    check("t4_trig", 64'(trig), 64'hA01);
    check("t4_meta", 64'(meta), 64'h01);

    // drop counter saturation
    req_trig[24 +: 12] = 12'hB00;
    req_valid[2] = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    req_valid = '0;
    check("t4_sat", drops, 64'hFFFF_0000_0000);
    tick();
    check("t4_sat2", drops, 64'hFFFF_0000_0000);
    slot();
    check("t4_sv", 64'(valid), 64'd1);
    check("t4_st", 64'(trig), 64'hB00);

    // source disable flushes pending
    pulse(3, 12'h0C3, 8'h43);
    check("t5_pend", 64'(pending), 64'h8);
    src_en = 4'b0111;
    tick();
    check("t5_flush", 64'(pending), 64'd0);
    slot();
    check("t5_nog", 64'(valid), 64'd0);
    src_en = 4'hF;

    // runrst mid-holdoff
    holdoff = 8'd3;
    pulse(0, 12'h0C0, 8'h40);
    slot();
    check("t5_g0", 64'(valid), 64'd1);
    check("t5_s0", 64'(src), 64'd0);
    pulse(1, 12'h0C1, 8'h41);
    runrst = 1'b1;
    tick();
    runrst = 1'b0;
    check("t5_rpend", 64'(pending), 64'd0);
    check("t5_rdrop", drops, 64'd0);
    check("t5_rvld", 64'(valid), 64'd0);
    holdoff = 8'd0;
    pulse(3, 12'h0D3, 8'h53);
    slot();
    check("t5_g3", 64'(valid), 64'd1);
    check("t5_s3", 64'(src), 64'd3);
    check("t5_t3", 64'(trig), 64'h0D3);

    // order from reset pointer, optional pps priority
    runrst = 1'b1;
    tick();
    runrst = 1'b0;
    req_trig[35:0] = {12'h602, 12'h601, 12'h600};
    req_valid = 4'b0111;
    tick();
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      slot();
      check("t6_valid", 64'(valid), 64'd1);
      check("t6_src", 64'(src), 64'(ord6[i]));
    end

    // async reset during a grant cycle
    pulse(0, 12'h777, 8'h77);
    slot_ce = 1'b1;
    tick();
    check("ar_vhi", 64'(valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("ar_vlo", 64'(valid), 64'd0);
    check("ar_trig", 64'(trig), 64'd0);
    slot_ce = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_pend", 64'(pending), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
